modular_adder_seq: RTL and testbench

- Computes result = (A + B) mod p for the ECPA field-arithmetic datapath.
- It is the addition counterpart of the modular subtractor.
- A single LIMB-bit adder is reused across the operand limbs, least-significant limb first.
- Pass 1 forms S = A + B; pass 2 forms D = S − p; a final select writes S or D.
- It trades latency for area versus full-width parallel adders and feeds the point-add/double sequencer.

---
 rtl/ecpa_pkg.sv | 18 +
 rtl/limb_adder.sv | 18 +
 rtl/modular_adder_seq.sv | 132 +++++++++++++
 tb/tb_modular_adder_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ecpa_pkg.sv
// Shared constants and types for the ECPA field-arithmetic datapath.
// Holds no logic. The curve modulus here is the default operand for the benches.
package ecpa_pkg;

    localparam int ECPA_WIDTH = 256;
    localparam int ECPA_LIMB  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        SUB  = 2'd2,
        FIN  = 2'd3
    } ecpa_state_t;

    localparam logic [ECPA_WIDTH-1:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

endpackage

// File: rtl/limb_adder.sv
// One limb-wide adder with carry in and carry out.
// Latency: combinational, no registers.
// Backpressure: none; the outputs follow the inputs.
module limb_adder
    import ecpa_pkg::*;
#(
    parameter int LIMB = ECPA_LIMB
) (
    input  logic [LIMB-1:0] a,
    input  logic [LIMB-1:0] b,
    input  logic            cin,
    output logic [LIMB-1:0] sum,
    output logic            cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{LIMB{1'b0}}, cin};

endmodule

// File: rtl/modular_adder_seq.sv
// Limb-serial (A + B) mod p: forms S = A + B, then D = S - p, then selects S or D.
// Latency: done arrives 2*NLIMB+1 edges after the accepted start.
// Backpressure: i_start is only accepted in IDLE; a request made while busy is dropped.
module modular_adder_seq
    import ecpa_pkg::*;
#(
    parameter int WIDTH = ECPA_WIDTH,
    parameter int LIMB  = ECPA_LIMB
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam int NLIMB = WIDTH / LIMB;
    localparam int KW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam int OW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NLIMB - 1);

    ecpa_state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, p_q;
    logic [WIDTH-1:0] s_q, d_q;
    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic             c_add_q, c_sub_q;

    logic             last_limb;
    logic [OW-1:0]    off;
    logic [LIMB-1:0]  op_a, op_b, limb_sum;
    logic             limb_cout;

    assign last_limb = (k_q == K_LAST);
    assign off       = OW'(k_q) * OW'(LIMB);
    assign busy      = (state_q != IDLE);

    // The subtract pass reuses the adder: S + ~p + 1 with the carry preset to 1.
    assign op_a = (state_q == SUB) ? s_q[off +: LIMB]  : a_q[off +: LIMB];
    assign op_b = (state_q == SUB) ? ~p_q[off +: LIMB] : b_q[off +: LIMB];

    limb_adder #(
        .LIMB (LIMB)
    ) u_limb_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (carry_q),
        .sum  (limb_sum),
        .cout (limb_cout)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = ADD;
            ADD:     if (last_limb) state_d = SUB;
            SUB:     if (last_limb) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            s_q     <= '0;
            d_q     <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            c_add_q <= 1'b0;
            c_sub_q <= 1'b0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        a_q     <= A;
                        b_q     <= B;
                        p_q     <= p;
                        k_q     <= '0;
                        carry_q <= 1'b0;
                    end
                end
                ADD: begin
                    s_q[off +: LIMB] <= limb_sum;
                    if (last_limb) begin
                        c_add_q <= limb_cout;
                        carry_q <= 1'b1;
                        k_q     <= '0;
                    end else begin
                        carry_q <= limb_cout;
                        k_q     <= k_q + KW'(1);
                    end
                end
                SUB: begin
                    d_q[off +: LIMB] <= limb_sum;
                    carry_q          <= limb_cout;
                    if (last_limb) begin
                        c_sub_q <= limb_cout;
                        k_q     <= '0;
                    end else begin
                        k_q     <= k_q + KW'(1);
                    end
                end
                FIN: begin
                    // Carry out of the add means the sum wrapped past 2^WIDTH, so S >= p.
                    result <= (c_add_q | c_sub_q) ? d_q : s_q;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modular_adder_seq.sv
// Scenario bench for modular_adder_seq: expected sums come from a wide-integer model.
module tb_modular_adder_seq;
    import ecpa_pkg::*;

    localparam int W = 256;

    logic         i_clk   = 1'b0;
    logic         i_rst   = 1'b1;
    logic         i_start = 1'b0;
    logic [W-1:0] A       = '0;
    logic [W-1:0] B       = '0;
    logic [W-1:0] p       = '0;
    logic [W-1:0] result;
    logic         done;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    modular_adder_seq dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .A       (A),
        .B       (B),
        .p       (p),
        .result  (result),
        .done    (done),
        .busy    (busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [W-1:0] ref_mod_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_below(input logic [W-1:0] m);
        logic [W-1:0] x;
        for (int i = 0; i < W / 32; i++) x[i*32 +: 32] = $urandom;
        if (x >= m) x = x - m;
        return x;
    endfunction

    // Drives one request and follows it to done, recording what the DUT showed on the way.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [W-1:0] res, output int busy_cyc,
                          output logic busy_at_done, output logic held, output logic timed_out);
        logic [W-1:0] prev;
        @(negedge i_clk);
        A = a; B = b; p = SECP256K1_P; i_start = 1'b1;
        exp_q.push_back(ref_mod_add(a, b, SECP256K1_P));
        @(posedge i_clk); #1;
        i_start = 1'b0; A = ~a; B = ~b; p = ~SECP256K1_P;
        prev = result;
        busy_cyc = busy ? 1 : 0;
        lat = 0; res = '0; busy_at_done = 1'b0; held = 1'b1; timed_out = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge i_clk); #1;
            if (done) begin
                lat = n; res = result; busy_at_done = busy; timed_out = 1'b0;
                break;
            end
            if (busy) busy_cyc++;
            if (result !== prev) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge i_clk); i_rst = 1'b0;
        @(posedge i_clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int lat, bc; logic [W-1:0] res, e; logic bd, held, to;
        run_op(W'(5), W'(7), lat, res, bc, bd, held, to);
        e = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL basic_done: no done within 30 edges"); end
        checks++; if (res !== e) begin errors++; $display("FAIL basic_result: got %h want %h", res, e); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", lat); end
        checks++; if (bc !== 9) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 9", bc); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", bd); end
        @(posedge i_clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        checks++; if (result !== e) begin errors++; $display("FAIL basic_hold: got %h want %h", result, e); end
    endtask

    task automatic test_carry_chain();
        int lat, bc; logic [W-1:0] res, e; logic bd, held, to;
        run_op(W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), lat, res, bc, bd, held, to);
        e = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL carry_done: no done within 30 edges"); end
        checks++; if (res !== e) begin errors++; $display("FAIL carry_result: got %h want %h", res, e); end
    endtask

    task automatic test_wrap_exact();
        int lat, bc; logic [W-1:0] res, e; logic bd, held, to;
        run_op(SECP256K1_P - W'(1), W'(1), lat, res, bc, bd, held, to);
        e = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL wrap_done: no done within 30 edges"); end
        checks++; if (res !== e) begin errors++; $display("FAIL wrap_result: got %h want %h", res, e); end
    endtask

    task automatic test_overflow();
        int lat, bc; logic [W-1:0] res, e; logic bd, held, to;
        run_op(SECP256K1_P - W'(1), SECP256K1_P - W'(1), lat, res, bc, bd, held, to);
        e = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL ovf_done: no done within 30 edges"); end
        checks++; if (res !== e) begin errors++; $display("FAIL ovf_result: got %h want %h", res, e); end
    endtask

    task automatic test_back_to_back();
        int lat, bc; logic [W-1:0] res, e; logic bd, held, to;
        run_op(W'(0), W'(0), lat, res, bc, bd, held, to);
        e = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL b2b0_done: no done within 30 edges"); end
        checks++; if (res !== e) begin errors++; $display("FAIL b2b0_result: got %h want %h", res, e); end
        checks++; if (!held) begin errors++; $display("FAIL b2b0_hold: result changed before done, want held"); end
        run_op(W'(3), W'(4), lat, res, bc, bd, held, to);
        e = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL b2b1_done: no done within 30 edges"); end
        checks++; if (res !== e) begin errors++; $display("FAIL b2b1_result: got %h want %h", res, e); end
        checks++; if (!held) begin errors++; $display("FAIL b2b1_hold: result changed before done, want held"); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL b2b1_latency: got %0d want 9", lat); end
    endtask

    task automatic test_start_while_busy();
        int lat, extra; logic [W-1:0] res, e; logic to;
        @(negedge i_clk);
        A = W'(11); B = W'(22); p = SECP256K1_P; i_start = 1'b1;
        exp_q.push_back(ref_mod_add(W'(11), W'(22), SECP256K1_P));
        @(posedge i_clk); #1;
        // Keep start asserted with different operands through the FIN edge.
        A = W'(1000); B = W'(2000);
        lat = 0; res = '0; to = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge i_clk); #1;
            if (done) begin lat = n; res = result; to = 1'b0; break; end
        end
        i_start = 1'b0;
        e = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL busy_start_done: no done within 30 edges"); end
        checks++; if (res !== e) begin errors++; $display("FAIL busy_start_result: got %h want %h", res, e); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL busy_start_latency: got %0d want 9", lat); end
        extra = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge i_clk); #1;
            if (done) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_queued: got %0d extra done want 0", extra); end
    endtask

    task automatic test_abort();
        int dn, lat, bc; logic [W-1:0] res, e; logic bd, held, to;
        @(negedge i_clk);
        A = W'(5); B = W'(9); p = SECP256K1_P; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk); i_rst = 1'b1;
        #1;
        checks++; if (result !== '0) begin errors++; $display("FAIL abort_result: got %h want 0", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        @(negedge i_clk); i_rst = 1'b0;
        dn = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge i_clk); #1;
            if (done) dn++;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL abort_done: got %0d done pulses want 0", dn); end
        run_op(W'(10), W'(20), lat, res, bc, bd, held, to);
        e = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL after_abort_done: no done within 30 edges"); end
        checks++; if (res !== e) begin errors++; $display("FAIL after_abort_result: got %h want %h", res, e); end
    endtask

    task automatic test_random();
        int lat, bc; logic [W-1:0] res, e, a, b; logic bd, held, to;
        for (int i = 0; i < 6; i++) begin
            a = rand_below(SECP256K1_P);
            b = rand_below(SECP256K1_P);
            run_op(a, b, lat, res, bc, bd, held, to);
            e = exp_q.pop_front();
            checks++; if (to) begin errors++; $display("FAIL rand%0d_done: no done within 30 edges", i); end
            checks++; if (res !== e) begin errors++; $display("FAIL rand%0d_result: got %h want %h", i, res, e); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_wrap_exact();
        test_overflow();
        test_back_to_back();
        test_start_while_busy();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
